huffman_encoder: RTL

Serial Huffman encoder: the transmit-side counterpart of the `huffman` serial decoder. It accepts 5-bit symbols over a valid/ready handshake and looks each one up in a fixed prefix-code table. It then emits the code one bit per accepted beat, MSB first, on a serial valid/ready interface that connects directly to the decoder's `serial_i`/`ready` pair. It sits between the symbol source and the serial link and shares its code table with the decoder through a common package.

---
 rtl/huffman_pkg.sv | 29 ++
 rtl/huffman_code_rom.sv | 11 +
 rtl/huffman_encoder.sv | 83 ++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared Huffman code table and FSM state type for the serial encoder/decoder pair.
package huffman_pkg;

  localparam int unsigned SYM_WIDTH    = 5;
  localparam int unsigned MAX_CODE_LEN = 6;

  typedef struct packed {
    logic [2:0] len;
    logic [5:0] code;
  } huff_code_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } huff_state_t;

  // Codes are right-aligned in the code field; symbols 0..3 get {0,s[1:0]}, the rest {1,s[4:0]}.
  localparam huff_code_t HUFF_TABLE [32] = '{
    '{3'd3, 6'd0},  '{3'd3, 6'd1},  '{3'd3, 6'd2},  '{3'd3, 6'd3},
    '{3'd6, 6'd36}, '{3'd6, 6'd37}, '{3'd6, 6'd38}, '{3'd6, 6'd39},
    '{3'd6, 6'd40}, '{3'd6, 6'd41}, '{3'd6, 6'd42}, '{3'd6, 6'd43},
    '{3'd6, 6'd44}, '{3'd6, 6'd45}, '{3'd6, 6'd46}, '{3'd6, 6'd47},
    '{3'd6, 6'd48}, '{3'd6, 6'd49}, '{3'd6, 6'd50}, '{3'd6, 6'd51},
    '{3'd6, 6'd52}, '{3'd6, 6'd53}, '{3'd6, 6'd54}, '{3'd6, 6'd55},
    '{3'd6, 6'd56}, '{3'd6, 6'd57}, '{3'd6, 6'd58}, '{3'd6, 6'd59},
    '{3'd6, 6'd60}, '{3'd6, 6'd61}, '{3'd6, 6'd62}, '{3'd6, 6'd63}
  };

endpackage

// File: rtl/huffman_code_rom.sv
// Combinational symbol -> {length, code} lookup into the shared Huffman table.
module huffman_code_rom
  import huffman_pkg::*;
(
  input  logic [SYM_WIDTH-1:0] symbol_i,
  output huff_code_t           entry_o
);

  assign entry_o = HUFF_TABLE[symbol_i];

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: symbol in over valid/ready, code out MSB-first one bit per beat.
// Optional bit counter port enabled by defining HUFFMAN_ENC_CNT_EN.
module huffman_encoder #(
  parameter int unsigned SYM_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH = 8
`ifdef HUFFMAN_ENC_CNT_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [SYM_WIDTH-1:0] symbol_i,
  input  logic                 sym_valid_i,
  output logic                 sym_ready_o,
  output logic                 serial_o,
  output logic                 valid_o,
  input  logic                 ready_i
`ifdef HUFFMAN_ENC_CNT_EN
  , output logic [CNT_WIDTH-1:0] bit_count_o
`endif
);

  import huffman_pkg::*;

  huff_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [2:0]            r_bits_left;

  huff_code_t            w_entry;
  logic [DATA_WIDTH-1:0] w_aligned;
  logic                  w_fire;
  logic                  w_last;
  logic                  w_accept;

  huffman_code_rom u_rom (
    .symbol_i (symbol_i),
    .entry_o  (w_entry)
  );

  // Left-align the variable-length code so its MSB lands in r_shreg[DATA_WIDTH-1].
  assign w_aligned = DATA_WIDTH'(w_entry.code) << (DATA_WIDTH - 32'(w_entry.len));

  assign valid_o     = (r_state == ST_SHIFT);
  assign serial_o    = valid_o & r_shreg[DATA_WIDTH-1];
  assign w_fire      = valid_o & ready_i;
  assign w_last      = w_fire & (r_bits_left == 3'd1);
  // Accepting during the last bit (combinational on ready_i) removes the bubble between codes.
  assign sym_ready_o = (r_state == ST_IDLE) | w_last;
  assign w_accept    = sym_valid_i & sym_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_bits_left <= '0;
    end else if (w_accept) begin
      r_state     <= ST_SHIFT;
      r_shreg     <= w_aligned;
      r_bits_left <= w_entry.len;
    end else if (w_fire) begin
      r_shreg     <= r_shreg << 1;
      r_bits_left <= r_bits_left - 3'd1;
      if (w_last) begin
        r_state <= ST_IDLE;
      end
    end
  end

`ifdef HUFFMAN_ENC_CNT_EN
  logic [CNT_WIDTH-1:0] r_bit_count;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_bit_count <= '0;
    end else if (w_fire && (r_bit_count != '1)) begin
      r_bit_count <= r_bit_count + 1'b1;
    end
  end

  assign bit_count_o = r_bit_count;
`endif

endmodule
